regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width.
REQ-002 SHALL have port clk  input  1  clock; all state updates on posedge clk.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have ports iss_valid/iss_rd  input  1/5  issue request reserving destination register iss_rd.
REQ-005 SHALL have port iss_ready  output  1  issue may fire this cycle.
REQ-006 SHALL have ports rs1_addr/rs2_addr  input  5/5  source registers of the instruction being decoded.
REQ-007 SHALL have ports rs1_busy/rs2_busy  output  1/1  source not yet readable from the register file.
REQ-008 SHALL have ports exu_valid/exu_rd/exu_data  input  1/5/WIDTH  ALU writeback request.
REQ-009 SHALL have port exu_ready  output  1  ALU writeback accepted this cycle.
REQ-010 SHALL have ports lsu_valid/lsu_rd/lsu_data  input  1/5/WIDTH  load writeback request.
REQ-011 SHALL have port lsu_ready  output  1  load writeback accepted this cycle.
REQ-012 SHALL have ports rf_wen/rf_rd_addr/rf_rd_data  output  1/5/WIDTH  register file write port, registered.
REQ-013 SHALL have port flush  input  1  discard all reservations.

Function
REQ-014 SHALL hold a 32-bit busy vector; bit 0 never set.
REQ-015 SHALL drive iss_ready = 1 when iss_rd==0, else !busy[iss_rd] (WAW stall); iss_ready is not gated by iss_valid.
REQ-016 SHALL set busy[iss_rd] at the edge where iss_valid&iss_ready and iss_rd!=0.
REQ-017 SHALL drive rsN_busy = (rsN_addr!=0) & (busy[rsN_addr] | (rf_wen & rf_rd_addr==rsN_addr)); this covers a write still in the output register.
REQ-018 SHALL grant at most one writeback per cycle; a transfer occurs when valid&ready.
REQ-019 SHALL arbitrate round-robin using a 1-bit last-grant pointer, reset to EXU.
- Both valid: grant the requester not granted last.
- One valid: grant it regardless of pointer.
REQ-020 SHALL update the pointer only on a transfer.
REQ-021 SHALL keep ready combinational from valid and pointer; ready SHALL never be asserted to a non-valid requester.
REQ-022 SHALL clear busy[rd] of the granted request at the accept edge.
REQ-023 SHALL register the granted request into rf_wen/rf_rd_addr/rf_rd_data one cycle after accept; rf_wen=0 when no grant or granted rd==0.
REQ-024 SHALL accept rd==0 writebacks normally but without a register file write.
REQ-025 SHALL let set win over clear when issue and writeback target the same rd in the same cycle; this is reachable only when busy was clear.
REQ-026 SHALL, on flush, clear every busy bit at that edge and ignore any same-cycle issue reservation.
REQ-027 SHALL still accept and perform writebacks during flush; the rf write completes normally.
REQ-028 SHALL hold rf_rd_addr/rf_rd_data at their last values when rf_wen=0.
REQ-029 SHALL let a requester hold valid with stable rd/data until ready; rd/data changes while stalled are not supported.

Reset
REQ-030 SHALL, while rst=1 at a posedge, clear busy to 0, set the pointer to EXU, and clear rf_wen, rf_rd_addr and rf_rd_data to 0.
REQ-031 SHALL drop any in-flight accept on the reset edge: no busy update and no rf write follow it.
REQ-032 SHALL keep the ready outputs as defined by REQ-015/021 during reset; the bench SHALL not count handshakes during reset.

Verification
REQ-033 SHALL cover reserve/release:
- Issue rd=5, then rs1_addr=5 gives rs1_busy=1.
- EXU writes rd=5 data 0x1234; next cycle rf_wen=1, addr=5, data=0x1234, rs1_busy=1.
- Following cycle rs1_busy=0.
REQ-034 SHALL cover contention: EXU and LSU valid for 4 cycles (rd 1..4) with pointer at reset.
- Grants SHALL be LSU, EXU, LSU, EXU.
- Each rf write follows its grant by one cycle.
REQ-035 SHALL cover the WAW stall: busy[7] set and iss_rd=7 gives iss_ready=0; LSU writes rd=7 and iss_ready=1 on the next cycle.
REQ-036 SHALL cover x0: iss_rd=0 gives iss_ready=1 and busy unchanged; EXU rd=0 gives exu_ready=1 and rf_wen stays 0.
REQ-037 SHALL cover flush: busy={3,9}, flush with issue rd=12 in the same cycle gives busy=0 and rs1_busy(12)=0.
REQ-038 SHALL cover reset mid-operation: accept on EXU rd=6 on the reset edge gives rf_wen=0 next cycle and busy=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Scoreboard of pending destination registers plus a round-robin arbiter that
// merges ALU and load writebacks onto a single registered register-file write port.
module regfile_wb_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  output logic             iss_ready,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  input  logic             exu_valid,
  input  logic [4:0]       exu_rd,
  input  logic [WIDTH-1:0] exu_data,
  output logic             exu_ready,
  input  logic             lsu_valid,
  input  logic [4:0]       lsu_rd,
  input  logic [WIDTH-1:0] lsu_data,
  output logic             lsu_ready,
  output logic             rf_wen,
  output logic [4:0]       rf_rd_addr,
  output logic [WIDTH-1:0] rf_rd_data,
  input  logic             flush
);

  typedef enum logic {LAST_EXU = 1'b0, LAST_LSU = 1'b1} last_t;

  last_t            last_q, last_d;
  logic [31:0]      busy_q, busy_d;
  logic             wb_fire;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             iss_fire;

  // State register: pointer, scoreboard and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= LAST_EXU;
      busy_q     <= '0;
      rf_wen     <= 1'b0;
      rf_rd_addr <= '0;
      rf_rd_data <= '0;
    end else begin
      last_q <= last_d;
      busy_q <= busy_d;
      rf_wen <= wb_fire && (wb_rd != 5'd0);
      if (wb_fire && (wb_rd != 5'd0)) begin
        rf_rd_addr <= wb_rd;
        rf_rd_data <= wb_data;
      end
    end
  end

  // Output logic: grants, issue readiness and operand hazards.
  always_comb begin
    exu_ready = exu_valid && (!lsu_valid || (last_q == LAST_LSU));
    lsu_ready = lsu_valid && (!exu_valid || (last_q == LAST_EXU));
    wb_fire   = exu_ready || lsu_ready;
    wb_rd     = lsu_ready ? lsu_rd   : exu_rd;
    wb_data   = lsu_ready ? lsu_data : exu_data;
    iss_ready = (iss_rd == 5'd0) || !busy_q[iss_rd];
    iss_fire  = iss_valid && iss_ready && (iss_rd != 5'd0);
    // A value still sitting in the write register is not yet visible in the file.
    rs1_busy  = (rs1_addr != 5'd0) &&
                (busy_q[rs1_addr] || (rf_wen && (rf_rd_addr == rs1_addr)));
    rs2_busy  = (rs2_addr != 5'd0) &&
                (busy_q[rs2_addr] || (rf_wen && (rf_rd_addr == rs2_addr)));
  end

  // Next state: release before reserve so a same-cycle reservation survives.
  always_comb begin
    last_d = last_q;
    busy_d = busy_q;
    if (exu_ready)      last_d = LAST_EXU;
    else if (lsu_ready) last_d = LAST_LSU;
    if (wb_fire) busy_d[wb_rd] = 1'b0;
    if (flush)         busy_d = '0;
    else if (iss_fire) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

endmodule
